// File: rtl/riscv_v_uop_sequencer.sv
// Expands one decoded vector instruction into LMUL register-group micro-ops,
// stalled by en and flushed in lock-step with the downstream vector stages.
module riscv_v_uop_sequencer #(
  parameter int OPC_W = 4,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPC_W-1:0] in_opcode,
  input  logic [REG_W-1:0] in_vd,
  input  logic [REG_W-1:0] in_vs1,
  input  logic [REG_W-1:0] in_vs2,
  input  logic [2:0]       in_vlmul,
  output logic             out_valid,
  output logic [OPC_W-1:0] out_opcode,
  output logic [REG_W-1:0] out_vd,
  output logic [REG_W-1:0] out_vs1,
  output logic [REG_W-1:0] out_vs2,
  output logic [2:0]       out_uop_idx,
  output logic             out_last,
  output logic             out_illegal,
  output logic             busy
);

  typedef enum logic {IDLE = 1'b0, SEQ = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [2:0]       uop_idx;
  logic [2:0]       cnt_m1;
  logic             illegal;
  logic [OPC_W-1:0] opcode;
  logic [REG_W-1:0] vd, vs1, vs2;

  logic             last;
  logic             accept;
  logic             dec_illegal;
  logic [2:0]       dec_cnt_m1;

  // Returns {illegal, count-1}; misaligned groups collapse to a single illegal uop.
  function automatic logic [3:0] decode(input logic [2:0]       vlmul,
                                        input logic [REG_W-1:0] a,
                                        input logic [REG_W-1:0] b,
                                        input logic [REG_W-1:0] c);
    logic [2:0]       m;
    logic             ill;
    logic [REG_W-1:0] low;
    m   = 3'd0;
    ill = 1'b0;
    case (vlmul)
      3'b001:  m = 3'd1;
      3'b010:  m = 3'd3;
      3'b011:  m = 3'd7;
      3'b100:  ill = 1'b1;
      default: m = 3'd0;
    endcase
    low = (a | b | c) & REG_W'(m);
    if (low != '0) begin
      m   = 3'd0;
      ill = 1'b1;
    end
    return {ill, m};
  endfunction

  assign {dec_illegal, dec_cnt_m1} = decode(in_vlmul, in_vd, in_vs1, in_vs2);

  assign last   = (state == SEQ) && (uop_idx == cnt_m1);
  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_nxt = SEQ;
        SEQ:     if (en && last) state_nxt = accept ? SEQ : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Capture on accept; the index only advances on a non-final transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uop_idx <= 3'd0;
      cnt_m1  <= 3'd0;
      illegal <= 1'b0;
      opcode  <= '0;
      vd      <= '0;
      vs1     <= '0;
      vs2     <= '0;
    end else if (flush) begin
      uop_idx <= 3'd0;
    end else if (accept) begin
      uop_idx <= 3'd0;
      cnt_m1  <= dec_cnt_m1;
      illegal <= dec_illegal;
      opcode  <= in_opcode;
      vd      <= in_vd;
      vs1     <= in_vs1;
      vs2     <= in_vs2;
    end else if (state == SEQ && en && !last) begin
      uop_idx <= uop_idx + 3'd1;
    end
  end

  always_comb begin
    in_ready    = !flush && ((state == IDLE) || (last && en));
    out_valid   = (state == SEQ);
    busy        = (state == SEQ);
    out_last    = last;
    out_illegal = (state == SEQ) && illegal;
    out_opcode  = opcode;
    out_uop_idx = uop_idx;
    out_vd      = vd  | REG_W'(uop_idx);
    out_vs1     = vs1 | REG_W'(uop_idx);
    out_vs2     = vs2 | REG_W'(uop_idx);
  end

endmodule

// File: tb/tb_riscv_v_uop_sequencer.sv
// Directed bench for riscv_v_uop_sequencer: a queue-based expansion model checked
// every cycle, plus literal expectations for each scenario.
module tb_riscv_v_uop_sequencer;

  localparam int OPC_W = 4;
  localparam int REG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n, flush, en, in_valid, in_ready;
  logic [OPC_W-1:0] in_opcode;
  logic [REG_W-1:0] in_vd, in_vs1, in_vs2;
  logic [2:0]       in_vlmul;
  logic             out_valid, out_last, out_illegal, busy;
  logic [OPC_W-1:0] out_opcode;
  logic [REG_W-1:0] out_vd, out_vs1, out_vs2;
  logic [2:0]       out_uop_idx;

  int checks = 0;
  int errors = 0;

  riscv_v_uop_sequencer #(.OPC_W(OPC_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .en(en),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_vd(in_vd), .in_vs1(in_vs1), .in_vs2(in_vs2), .in_vlmul(in_vlmul),
    .out_valid(out_valid), .out_opcode(out_opcode), .out_vd(out_vd),
    .out_vs1(out_vs1), .out_vs2(out_vs2), .out_uop_idx(out_uop_idx),
    .out_last(out_last), .out_illegal(out_illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int op; int vd; int vs1; int vs2; int idx; bit last; bit ill;
  } uop_t;

  uop_t q[$];

  // Model: an instruction becomes a list of uops the moment it is accepted.
  task automatic expand(input int op, input int vd, input int vs1, input int vs2, input int vlmul);
    int  n;
    bit  ill;
    uop_t u;
    ill = 0;
    case (vlmul)
      0: n = 1;
      1: n = 2;
      2: n = 4;
      3: n = 8;
      4: begin n = 1; ill = 1; end
      default: n = 1;
    endcase
    if (vd % n != 0 || vs1 % n != 0 || vs2 % n != 0) begin
      n = 1;
      ill = 1;
    end
    for (int i = 0; i < n; i++) begin
      u.op = op; u.vd = vd + i; u.vs1 = vs1 + i; u.vs2 = vs2 + i;
      u.idx = i; u.last = (i == n - 1); u.ill = ill;
      q.push_back(u);
    end
  endtask

  always @(negedge clk) begin
    int n;
    bit ready_m;
    n = q.size();
    if (!rst_n) begin
      q.delete();
      lit("m_rst_valid", out_valid, 0);
      lit("m_rst_busy", busy, 0);
    end else begin
      ready_m = !flush && (n == 0 || (n == 1 && en));
      lit("m_valid", out_valid, n > 0);
      lit("m_busy", busy, n > 0);
      lit("m_ready", in_ready, ready_m);
      if (n > 0) begin
        lit("m_opcode", out_opcode, q[0].op);
        lit("m_vd", out_vd, q[0].vd);
        lit("m_vs1", out_vs1, q[0].vs1);
        lit("m_vs2", out_vs2, q[0].vs2);
        lit("m_idx", out_uop_idx, q[0].idx);
        lit("m_last", out_last, q[0].last);
        lit("m_illegal", out_illegal, q[0].ill);
      end
      if (flush) begin
        q.delete();
      end else begin
        if (n > 0 && en) void'(q.pop_front());
        if (in_valid && ready_m)
          expand(int'(in_opcode), int'(in_vd), int'(in_vs1), int'(in_vs2), int'(in_vlmul));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int op, input int vd, input int vs1, input int vs2, input int vlmul);
    in_opcode = OPC_W'(op);
    in_vd     = REG_W'(vd);
    in_vs1    = REG_W'(vs1);
    in_vs2    = REG_W'(vs2);
    in_vlmul  = 3'(vlmul);
    in_valid  = 1'b1;
  endtask

  initial begin
    int xfers;
    rst_n = 1'b0; flush = 1'b0; en = 1'b0; in_valid = 1'b0;
    in_opcode = '0; in_vd = '0; in_vs1 = '0; in_vs2 = '0; in_vlmul = '0;
    #3;
    lit("reset_valid", out_valid, 0);
    lit("reset_busy", busy, 0);
    lit("reset_last", out_last, 0);
    lit("reset_illegal", out_illegal, 0);
    lit("reset_vd", out_vd, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // single uop, LMUL=1
    en = 1'b1;
    drive(1, 3, 4, 5, 0);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    lit("t1_valid", out_valid, 1);
    lit("t1_vd", out_vd, 3);
    lit("t1_vs1", out_vs1, 4);
    lit("t1_vs2", out_vs2, 5);
    lit("t1_idx", out_uop_idx, 0);
    lit("t1_last", out_last, 1);
    lit("t1_illegal", out_illegal, 0);
    step();
    @(negedge clk);
    lit("t1_done", out_valid, 0);
    step();

    // LMUL=8 group
    drive(2, 8, 16, 24, 3);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      lit("t2_vd", out_vd, 8 + i);
      lit("t2_vs1", out_vs1, 16 + i);
      lit("t2_vs2", out_vs2, 24 + i);
      lit("t2_last", out_last, i == 7);
      lit("t2_ready", in_ready, i == 7);
      step();
    end
    @(negedge clk);
    lit("t2_done", out_valid, 0);
    step();

    // LMUL=4 with en toggling
    drive(3, 8, 0, 4, 2);
    step();
    in_valid = 1'b0;
    xfers = 0;
    for (int c = 0; c < 8; c++) begin
      en = (c % 2 == 1);
      @(negedge clk);
      if (out_valid && en) begin
        lit("t3_idx", out_uop_idx, xfers);
        xfers++;
      end
      step();
    end
    lit("t3_count", xfers, 4);
    en = 1'b1;
    @(negedge clk);
    lit("t3_done", out_valid, 0);
    step();

    // misaligned LMUL=2 and reserved vlmul
    drive(4, 3, 4, 6, 1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    lit("t4a_illegal", out_illegal, 1);
    lit("t4a_last", out_last, 1);
    lit("t4a_vd", out_vd, 3);
    step();
    drive(5, 8, 16, 24, 4);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    lit("t4b_illegal", out_illegal, 1);
    lit("t4b_last", out_last, 1);
    lit("t4b_idx", out_uop_idx, 0);
    step();
    @(negedge clk);
    lit("t4b_done", out_valid, 0);
    step();

    // back-to-back instructions
    drive(6, 2, 4, 6, 1);
    step();
    drive(7, 10, 11, 12, 0);
    @(negedge clk);
    lit("t5_vd0", out_vd, 2);
    lit("t5_ready0", in_ready, 0);
    step();
    @(negedge clk);
    lit("t5_vd1", out_vd, 3);
    lit("t5_last1", out_last, 1);
    lit("t5_ready1", in_ready, 1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    lit("t5_valid2", out_valid, 1);
    lit("t5_vd2", out_vd, 10);
    lit("t5_op2", out_opcode, 7);
    step();
    @(negedge clk);
    lit("t5_done", out_valid, 0);
    step();

    // flush mid-group
    drive(8, 16, 20, 24, 2);
    step();
    in_valid = 1'b0;
    step();
    step();
    flush = 1'b1;
    drive(9, 7, 1, 2, 0);
    @(negedge clk);
    lit("t6_ready_flush", in_ready, 0);
    step();
    flush = 1'b0;
    @(negedge clk);
    lit("t6_valid", out_valid, 0);
    lit("t6_busy", busy, 0);
    lit("t6_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    lit("t6_new_valid", out_valid, 1);
    lit("t6_new_vd", out_vd, 7);
    step();

    // asynchronous reset mid-group
    drive(10, 0, 8, 16, 3);
    step();
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    lit("t7_valid", out_valid, 0);
    lit("t7_busy", busy, 0);
    lit("t7_last", out_last, 0);
    lit("t7_illegal", out_illegal, 0);
    lit("t7_vd", out_vd, 0);
    lit("t7_opcode", out_opcode, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    @(negedge clk);
    lit("t7_after", out_valid, 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
